// File: rtl/axi_rr_arbiter_2x1.sv
// Two-master to one-slave AXI4 round-robin arbiter.
// The read and write channels are arbitrated independently of each other.
// A grant covers exactly one burst and is held until that burst completes.
// All payload routing is combinational from the registered grant.
// Valid/ready contract: a transfer happens on a channel in any cycle where
// both valid and ready are high. Valids never depend on ready. The arbiter
// only forwards a channel while its FSM is in the state that owns it. Every
// other valid, ready and payload output is driven to zero.
module axi_rr_arbiter_2x1 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // master 0
    input  logic                    s0_axi_awvalid,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic [7:0]              s0_axi_awlen,
    input  logic [2:0]              s0_axi_awsize,
    input  logic [1:0]              s0_axi_awburst,
    output logic                    s0_axi_awready,
    input  logic                    s0_axi_wvalid,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wlast,
    output logic                    s0_axi_wready,
    output logic                    s0_axi_bvalid,
    output logic [1:0]              s0_axi_bresp,
    input  logic                    s0_axi_bready,
    input  logic                    s0_axi_arvalid,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic [7:0]              s0_axi_arlen,
    input  logic [2:0]              s0_axi_arsize,
    input  logic [1:0]              s0_axi_arburst,
    output logic                    s0_axi_arready,
    output logic                    s0_axi_rvalid,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [1:0]              s0_axi_rresp,
    output logic                    s0_axi_rlast,
    input  logic                    s0_axi_rready,
    // master 1
    input  logic                    s1_axi_awvalid,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic [7:0]              s1_axi_awlen,
    input  logic [2:0]              s1_axi_awsize,
    input  logic [1:0]              s1_axi_awburst,
    output logic                    s1_axi_awready,
    input  logic                    s1_axi_wvalid,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wlast,
    output logic                    s1_axi_wready,
    output logic                    s1_axi_bvalid,
    output logic [1:0]              s1_axi_bresp,
    input  logic                    s1_axi_bready,
    input  logic                    s1_axi_arvalid,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic [7:0]              s1_axi_arlen,
    input  logic [2:0]              s1_axi_arsize,
    input  logic [1:0]              s1_axi_arburst,
    output logic                    s1_axi_arready,
    output logic                    s1_axi_rvalid,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic [1:0]              s1_axi_rresp,
    output logic                    s1_axi_rlast,
    input  logic                    s1_axi_rready,
    // interconnect s00
    output logic                    m_axi_awvalid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    input  logic                    m_axi_awready,
    output logic                    m_axi_wvalid,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    input  logic                    m_axi_wready,
    input  logic                    m_axi_bvalid,
    input  logic [1:0]              m_axi_bresp,
    output logic                    m_axi_bready,
    output logic                    m_axi_arvalid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    input  logic                    m_axi_arready,
    input  logic                    m_axi_rvalid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    output logic                    m_axi_rready,
    // FSM state observation: write 0..3 = IDLE/ADDR/DATA/RESP, read 0..2 = IDLE/ADDR/DATA
    output logic [1:0]              dbg_wstate_o,
    output logic [1:0]              dbg_rstate_o
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;
    logic    wgrant_q, wgrant_d, wptr_q, wptr_d;
    logic    rgrant_q, rgrant_d, rptr_q, rptr_d;

    assign dbg_wstate_o = wstate_q;
    assign dbg_rstate_o = rstate_q;

    // State, grant and round-robin pointer registers for both channels
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wstate_q <= W_IDLE;
            wgrant_q <= 1'b0;
            wptr_q   <= 1'b0;
            rstate_q <= R_IDLE;
            rgrant_q <= 1'b0;
            rptr_q   <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            wgrant_q <= wgrant_d;
            wptr_q   <= wptr_d;
            rstate_q <= rstate_d;
            rgrant_q <= rgrant_d;
            rptr_q   <= rptr_d;
        end
    end

    // Write next state: arbitrate in idle, then follow AW -> W(last) -> B
    always_comb begin
        wstate_d = wstate_q;
        wgrant_d = wgrant_q;
        wptr_d   = wptr_q;
        case (wstate_q)
            W_IDLE: if (s0_axi_awvalid || s1_axi_awvalid) begin
                wstate_d = W_ADDR;
                wgrant_d = (s0_axi_awvalid && s1_axi_awvalid) ? wptr_q : s1_axi_awvalid;
            end
            W_ADDR: if (m_axi_awvalid && m_axi_awready) wstate_d = W_DATA;
            W_DATA: if (m_axi_wvalid && m_axi_wready && m_axi_wlast) wstate_d = W_RESP;
            W_RESP: if (m_axi_bvalid && m_axi_bready) begin
                wstate_d = W_IDLE;
                // the master just served drops to lower priority
                wptr_d   = ~wgrant_q;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write outputs: route only the channel owned by the current state
    always_comb begin
        m_axi_awvalid = 1'b0; m_axi_awaddr = '0; m_axi_awlen = '0;
        m_axi_awsize = '0; m_axi_awburst = '0;
        m_axi_wvalid = 1'b0; m_axi_wdata = '0; m_axi_wstrb = '0; m_axi_wlast = 1'b0;
        m_axi_bready = 1'b0;
        s0_axi_awready = 1'b0; s1_axi_awready = 1'b0;
        s0_axi_wready = 1'b0; s1_axi_wready = 1'b0;
        s0_axi_bvalid = 1'b0; s1_axi_bvalid = 1'b0;
        s0_axi_bresp = '0; s1_axi_bresp = '0;
        case (wstate_q)
            W_ADDR: begin
                m_axi_awvalid = wgrant_q ? s1_axi_awvalid : s0_axi_awvalid;
                m_axi_awaddr  = wgrant_q ? s1_axi_awaddr  : s0_axi_awaddr;
                m_axi_awlen   = wgrant_q ? s1_axi_awlen   : s0_axi_awlen;
                m_axi_awsize  = wgrant_q ? s1_axi_awsize  : s0_axi_awsize;
                m_axi_awburst = wgrant_q ? s1_axi_awburst : s0_axi_awburst;
                if (wgrant_q) s1_axi_awready = m_axi_awready;
                else          s0_axi_awready = m_axi_awready;
            end
            W_DATA: begin
                m_axi_wvalid = wgrant_q ? s1_axi_wvalid : s0_axi_wvalid;
                m_axi_wdata  = wgrant_q ? s1_axi_wdata  : s0_axi_wdata;
                m_axi_wstrb  = wgrant_q ? s1_axi_wstrb  : s0_axi_wstrb;
                m_axi_wlast  = wgrant_q ? s1_axi_wlast  : s0_axi_wlast;
                if (wgrant_q) s1_axi_wready = m_axi_wready;
                else          s0_axi_wready = m_axi_wready;
            end
            W_RESP: begin
                m_axi_bready = wgrant_q ? s1_axi_bready : s0_axi_bready;
                if (wgrant_q) begin
                    s1_axi_bvalid = m_axi_bvalid;
                    s1_axi_bresp  = m_axi_bresp;
                end else begin
                    s0_axi_bvalid = m_axi_bvalid;
                    s0_axi_bresp  = m_axi_bresp;
                end
            end
            default: ;
        endcase
    end

    // Read next state: arbitrate in idle, then follow AR -> R(last)
    always_comb begin
        rstate_d = rstate_q;
        rgrant_d = rgrant_q;
        rptr_d   = rptr_q;
        case (rstate_q)
            R_IDLE: if (s0_axi_arvalid || s1_axi_arvalid) begin
                rstate_d = R_ADDR;
                rgrant_d = (s0_axi_arvalid && s1_axi_arvalid) ? rptr_q : s1_axi_arvalid;
            end
            R_ADDR: if (m_axi_arvalid && m_axi_arready) rstate_d = R_DATA;
            R_DATA: if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
                rstate_d = R_IDLE;
                rptr_d   = ~rgrant_q;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read outputs: route only the channel owned by the current state
    always_comb begin
        m_axi_arvalid = 1'b0; m_axi_araddr = '0; m_axi_arlen = '0;
        m_axi_arsize = '0; m_axi_arburst = '0;
        m_axi_rready = 1'b0;
        s0_axi_arready = 1'b0; s1_axi_arready = 1'b0;
        s0_axi_rvalid = 1'b0; s0_axi_rdata = '0; s0_axi_rresp = '0; s0_axi_rlast = 1'b0;
        s1_axi_rvalid = 1'b0; s1_axi_rdata = '0; s1_axi_rresp = '0; s1_axi_rlast = 1'b0;
        case (rstate_q)
            R_ADDR: begin
                m_axi_arvalid = rgrant_q ? s1_axi_arvalid : s0_axi_arvalid;
                m_axi_araddr  = rgrant_q ? s1_axi_araddr  : s0_axi_araddr;
                m_axi_arlen   = rgrant_q ? s1_axi_arlen   : s0_axi_arlen;
                m_axi_arsize  = rgrant_q ? s1_axi_arsize  : s0_axi_arsize;
                m_axi_arburst = rgrant_q ? s1_axi_arburst : s0_axi_arburst;
                if (rgrant_q) s1_axi_arready = m_axi_arready;
                else          s0_axi_arready = m_axi_arready;
            end
            R_DATA: begin
                m_axi_rready = rgrant_q ? s1_axi_rready : s0_axi_rready;
                if (rgrant_q) begin
                    s1_axi_rvalid = m_axi_rvalid; s1_axi_rdata = m_axi_rdata;
                    s1_axi_rresp  = m_axi_rresp;  s1_axi_rlast = m_axi_rlast;
                end else begin
                    s0_axi_rvalid = m_axi_rvalid; s0_axi_rdata = m_axi_rdata;
                    s0_axi_rresp  = m_axi_rresp;  s0_axi_rlast = m_axi_rlast;
                end
            end
            default: ;
        endcase
    end

endmodule
